// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller: state encoding,
// active-low gfedcba segment patterns and the digit-index width helper.
package fnd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_OFF   = 2'd0;
  localparam state_t ST_BLANK = 2'd1;
  localparam state_t ST_DRIVE = 2'd2;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int idx_width(input int digits);
    return (digits < 2) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/fnd_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment {g,f,e,d,c,b,a} decoder.
module fnd_hex_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // NOTE: a default assignment before the case keeps always_comb free of latches.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed common-anode FND scan controller with frame-boundary shadow load.
// Optional leading-zero blanking is enabled by defining FND_LZB_EN.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int TICK_DIV  = 131072,
  parameter int BLANK_CYC = 1024
) (
  input  logic                  clock_50m,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  upd_req,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  upd_ack,
  output logic [DIGITS-1:0]     fnd_com,
  output logic [7:0]            fnd_seg,
  output logic                  frame_done
);

  localparam int IW = idx_width(DIGITS);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t                state, state_nxt;
  logic [PW-1:0]         presc, presc_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic                  boundary;
  logic [4*DIGITS-1:0]   shadow_data;
  logic [DIGITS-1:0]     shadow_dp;
  logic [DIGITS-1:0]     lzb_mask;
  logic [3:0]            sel_nib;
  logic                  sel_dp;
  logic                  sel_lzb;
  logic [6:0]            dec_seg;
  logic [DIGITS-1:0]     com_nxt;
  logic [7:0]            seg_nxt;

  // Slot sequencing; enable low overrides everything and parks the scan at digit 0.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    idx_nxt   = idx;
    boundary  = 1'b0;
    if (!enable) begin
      state_nxt = ST_OFF;
      presc_nxt = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_nxt = ST_BLANK;
          presc_nxt = '0;
        end
        ST_BLANK: begin
          presc_nxt = presc + 1'b1;
          if (presc == PW'(BLANK_CYC - 1)) state_nxt = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (presc == PW'(TICK_DIV - 1)) begin
            state_nxt = ST_BLANK;
            presc_nxt = '0;
            if (idx == IW'(DIGITS - 1)) begin
              idx_nxt  = '0;
              boundary = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            presc_nxt = presc + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_OFF;
          presc_nxt = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

`ifdef FND_LZB_EN
  // A digit is blanked when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    logic zero_above;
    lzb_mask   = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above & (shadow_data[i*4 +: 4] == 4'd0);
      lzb_mask[i] = zero_above;
    end
  end
`else
  assign lzb_mask = '0;
`endif

  // Outputs are registered from the next-state view so commons and segments move together.
  always_comb begin
    sel_nib = '0;
    sel_dp  = 1'b0;
    sel_lzb = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IW'(i)) begin
        sel_nib = shadow_data[i*4 +: 4];
        sel_dp  = shadow_dp[i];
        sel_lzb = lzb_mask[i];
      end
    end
  end

  fnd_hex_decoder u_dec (
    .nibble (sel_nib),
    .seg    (dec_seg)
  );

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      com_nxt[i] = !((state_nxt == ST_DRIVE) && (idx_nxt == IW'(i)));
    end
    seg_nxt = (state_nxt == ST_DRIVE) ? {~sel_dp, sel_lzb ? SEG_BLANK : dec_seg} : 8'hFF;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      state       <= ST_OFF;
      presc       <= '0;
      idx         <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      fnd_com     <= '1;
      fnd_seg     <= 8'hFF;
      upd_ack     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      idx        <= idx_nxt;
      fnd_com    <= com_nxt;
      fnd_seg    <= seg_nxt;
      frame_done <= boundary;
      upd_ack    <= boundary && upd_req;
      if (boundary && upd_req) begin
        shadow_data <= digit_data;
        shadow_dp   <= dp_in;
      end
    end
  end

endmodule
